// File: rtl/hex_page_ctrl_if.sv
// hex_page_ctrl_if: bundles the debug-word input, the page controls and the
// per-digit nibble/blank outputs that feed the six hex7seg decoders.
// The master side drives value/load/page_btn/auto_en; the slave (the
// controller) drives the display nibbles, blank mask and current page.
interface hex_page_ctrl_if;
  logic [31:0] value;
  logic        load;
  logic        page_btn;
  logic        auto_en;
  logic [3:0]  hex0_val;
  logic [3:0]  hex1_val;
  logic [3:0]  hex2_val;
  logic [3:0]  hex3_val;
  logic [3:0]  hex4_val;
  logic [3:0]  hex5_val;
  logic [5:0]  blank;
  logic        page;

  modport master (
    output value, load, page_btn, auto_en,
    input  hex0_val, hex1_val, hex2_val, hex3_val, hex4_val, hex5_val,
    input  blank, page
  );

  modport slave (
    input  value, load, page_btn, auto_en,
    output hex0_val, hex1_val, hex2_val, hex3_val, hex4_val, hex5_val,
    output blank, page
  );
endinterface

// File: rtl/hex_page_ctrl.sv
// hex_page_ctrl: holds a 32-bit debug word and shows it one 16-bit half at a
// time on HEX3..HEX0, with the half index on HEX5. The half is toggled by a
// button rising edge or, in auto mode, by a PAGE_CYCLES-long timer.
// Optional feature macro: HEX_PAGE_LZS_EN enables leading-zero suppression
// on HEX3..HEX1 within the displayed half (HEX0 is always shown).
// All outputs decode registered state only; no input reaches an output
// combinationally.
module hex_page_ctrl #(
  parameter int PAGE_CYCLES = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  hex_page_ctrl_if.slave  bus
);

  localparam int CNT_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAGE_CYCLES - 1);

  logic [31:0]      held_q, held_d;
  logic             page_q, page_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             btn_q,  btn_d;

  logic             btn_rise;
  logic             tick;
  logic [15:0]      half;

  // Next-state: capture, button edge detect, page timer and page toggle
  always_comb begin
    held_d   = bus.load ? bus.value : held_q;
    btn_d    = bus.page_btn;
    btn_rise = bus.page_btn & ~btn_q;
    tick     = bus.auto_en && (cnt_q == CNT_MAX);
    page_d   = page_q;
    cnt_d    = cnt_q;
    if (!bus.auto_en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (btn_rise || tick) begin
      page_d = ~page_q;
      cnt_d  = '0;
    end
  end

  // State registers; btn_q resets high so a button held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= '0;
      page_q <= 1'b0;
      cnt_q  <= '0;
      btn_q  <= 1'b1;
    end else begin
      held_q <= held_d;
      page_q <= page_d;
      cnt_q  <= cnt_d;
      btn_q  <= btn_d;
    end
  end

  // Digit mapping and blank mask derived from the selected half
  always_comb begin
    half         = page_q ? held_q[31:16] : held_q[15:0];
    bus.hex0_val = half[3:0];
    bus.hex1_val = half[7:4];
    bus.hex2_val = half[11:8];
    bus.hex3_val = half[15:12];
    bus.hex4_val = 4'h0;
    bus.hex5_val = {3'b000, page_q};
    bus.page     = page_q;
    bus.blank    = 6'b010000;
`ifdef HEX_PAGE_LZS_EN
    bus.blank[3] = (half[15:12] == 4'h0);
    bus.blank[2] = (half[15:8]  == 8'h00);
    bus.blank[1] = (half[15:4]  == 12'h000);
`endif
  end

endmodule

// File: tb/tb_hex_page_ctrl.sv
// tb_hex_page_ctrl: scoreboard bench for hex_page_ctrl with PAGE_CYCLES = 4.
// A cycle model predicts the display after each edge; predictions are queued
// when stimulus is applied and popped/compared once the edge has happened.
// Directed checks cover the load, manual page, auto rotation, mid-run reset
// and blank-mask cases. Honours HEX_PAGE_LZS_EN in the same way as the DUT.
module tb_hex_page_ctrl;

  localparam int PC = 4;

  logic clk;
  logic rst;

  hex_page_ctrl_if bus ();

  hex_page_ctrl #(.PAGE_CYCLES(PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        page;
    logic [15:0] word;
    logic [3:0]  hex4;
    logic [3:0]  hex5;
    logic [5:0]  blank;
  } exp_t;

  exp_t sbQ[$];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0] mHeld;
  logic        mPage;
  int          mCnt;
  logic        mBtn;

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  function automatic logic [5:0] modelBlank(input logic [15:0] half);
    logic [5:0] b;
    logic       z;
    b = 6'b010000;
`ifdef HEX_PAGE_LZS_EN
    for (int i = 1; i < 4; i++) begin
      z = 1'b1;
      for (int j = i; j < 4; j++) begin
        if (half[4*j +: 4] != 4'h0) z = 1'b0;
      end
      b[i] = z;
    end
`endif
    return b;
  endfunction

  // Drive one cycle of inputs, advance the model, queue its prediction,
  // then let the edge happen and compare the DUT against the popped entry.
  task automatic applyStimulus(input logic r, input logic ld, input logic [31:0] v,
                               input logic btn, input logic au);
    exp_t e;
    exp_t got;
    logic rise;
    logic tk;
    logic [15:0] half;
    rst          = r;
    bus.load     = ld;
    bus.value    = v;
    bus.page_btn = btn;
    bus.auto_en  = au;
    if (r) begin
      mHeld = 32'h0;
      mPage = 1'b0;
      mCnt  = 0;
      mBtn  = 1'b1;
    end else begin
      rise = btn && !mBtn;
      tk   = au && (mCnt == PC - 1);
      if (ld) mHeld = v;
      if (rise || tk) begin
        mPage = ~mPage;
        mCnt  = 0;
      end else if (au) begin
        mCnt = mCnt + 1;
      end else begin
        mCnt = 0;
      end
      mBtn = btn;
    end
    half    = mPage ? mHeld[31:16] : mHeld[15:0];
    e.page  = mPage;
    e.word  = half;
    e.hex4  = 4'h0;
    e.hex5  = {3'b000, mPage};
    e.blank = modelBlank(half);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checkOutput("sb_page",  {31'b0, bus.page}, {31'b0, got.page});
    checkOutput("sb_word",  {16'b0, bus.hex3_val, bus.hex2_val, bus.hex1_val, bus.hex0_val},
                {16'b0, got.word});
    checkOutput("sb_hex4",  {28'b0, bus.hex4_val}, {28'b0, got.hex4});
    checkOutput("sb_hex5",  {28'b0, bus.hex5_val}, {28'b0, got.hex5});
    checkOutput("sb_blank", {26'b0, bus.blank},    {26'b0, got.blank});
  endtask

  initial begin
    int toggles;
    int gap;
    int guard;
    logic prevPage;
    logic [5:0] expBlank;

    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.page_btn = 1'b0; bus.auto_en = 1'b0;
    mHeld = '0; mPage = 1'b0; mCnt = 0; mBtn = 1'b1;
    #1;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_blank", {26'b0, bus.blank}, 32'h10);
    checkOutput("rst_hex5",  {28'b0, bus.hex5_val}, 32'h0);
    checkOutput("rst_hex0",  {28'b0, bus.hex0_val}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Load and show page 0
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 1'b0, 1'b0);
    checkOutput("ld_hex3", {28'b0, bus.hex3_val}, 32'hA);
    checkOutput("ld_hex2", {28'b0, bus.hex2_val}, 32'hB);
    checkOutput("ld_hex1", {28'b0, bus.hex1_val}, 32'hC);
    checkOutput("ld_hex0", {28'b0, bus.hex0_val}, 32'hD);
    checkOutput("ld_hex5", {28'b0, bus.hex5_val}, 32'h0);
    checkOutput("ld_blank", {26'b0, bus.blank}, 32'h10);

    // Button held high for 5 cycles: exactly one toggle
    toggles = 0;
    prevPage = bus.page;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (bus.page !== prevPage) toggles++;
      prevPage = bus.page;
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("btn_toggles", toggles, 1);
    checkOutput("pg1_word", {16'b0, bus.hex3_val, bus.hex2_val, bus.hex1_val, bus.hex0_val}, 32'h1234);
    checkOutput("pg1_hex5", {28'b0, bus.hex5_val}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("btn2_page", {31'b0, bus.page}, 32'h0);

    // Auto rotation: 12 edges from cnt=0 give 3 toggles
    toggles = 0;
    prevPage = bus.page;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      if (bus.page !== prevPage) toggles++;
      prevPage = bus.page;
    end
    checkOutput("auto_toggles", toggles, 3);

    // Button rise coinciding with cnt = PC-1: single toggle, then a full period
    guard = 0;
    while (mCnt != PC - 1 && guard < 20) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      guard++;
    end
    checkOutput("coinc_reach", {31'b0, (mCnt == PC - 1)}, 32'h1);
    prevPage = bus.page;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("coinc_toggle", {31'b0, bus.page}, {31'b0, ~prevPage});
    prevPage = bus.page;
    gap = 0;
    guard = 0;
    while (bus.page === prevPage && guard < 20) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      gap++;
      guard++;
    end
    checkOutput("coinc_gap", gap, PC);

    // Reset mid-operation with page 1, cnt 2, button high
    guard = 0;
    while (!(mPage == 1'b1 && mCnt == 2) && guard < 40) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      guard++;
    end
    checkOutput("mid_reach", {31'b0, (mPage == 1'b1 && mCnt == 2)}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    toggles = 0;
    prevPage = bus.page;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (bus.page !== prevPage) toggles++;
      prevPage = bus.page;
    end
    checkOutput("mid_page", {31'b0, bus.page}, 32'h0);
    checkOutput("mid_held", {16'b0, bus.hex3_val, bus.hex2_val, bus.hex1_val, bus.hex0_val}, 32'h0);
    checkOutput("mid_toggles", toggles, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Blank mask with a mostly-zero word on both pages
    applyStimulus(1'b0, 1'b1, 32'h0000_0050, 1'b0, 1'b0);
`ifdef HEX_PAGE_LZS_EN
    expBlank = 6'b011100;
`else
    expBlank = 6'b010000;
`endif
    checkOutput("lzs_pg0", {26'b0, bus.blank}, {26'b0, expBlank});
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef HEX_PAGE_LZS_EN
    expBlank = 6'b011110;
`else
    expBlank = 6'b010000;
`endif
    checkOutput("lzs_pg1", {26'b0, bus.blank}, {26'b0, expBlank});
    checkOutput("lzs_hex0", {28'b0, bus.hex0_val}, 32'h0);

    // Random traffic through the scoreboard
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                    $urandom() & (($urandom_range(0, 1) == 1) ? 32'h00F0_00F0 : 32'hFFFF_FFFF),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
